// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler: gathers WIDTH accepted bits into a word and
// holds it in a single output register behind a valid/ready handshake.
module bit_deserializer #(
  parameter int unsigned WIDTH     = 12,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] acc_seed;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             at_last;
  logic             partial;
  logic             accept;
  logic             consume;
  logic             dout_valid_nxt;
  logic             frame_err_nxt;

  assign at_last   = (cnt == LAST);
  assign partial   = (cnt != '0);
  // Only the closing bit of a word can stall, and only while the output is full.
  assign din_ready = !(at_last && dout_valid && !dout_ready);
  assign accept    = din_valid && din_ready;
  assign consume   = dout_valid && dout_ready;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign acc_shift = {din, acc[WIDTH-1:1]};
      assign acc_seed  = {din, {(WIDTH-1){1'b0}}};
    end else begin : g_msb
      assign acc_shift = {acc[WIDTH-2:0], din};
      assign acc_seed  = {{(WIDTH-1){1'b0}}, din};
    end
  endgenerate

  always_comb begin
    acc_nxt        = acc;
    cnt_nxt        = cnt;
    dout_nxt       = dout;
    dout_valid_nxt = dout_valid;
    frame_err_nxt  = frame_err;

    if (consume) begin
      dout_valid_nxt = 1'b0;
    end

    if (sync) begin
      // A sync bit always starts a fresh word, so it can never complete one.
      if (accept) begin
        acc_nxt = acc_seed;
        cnt_nxt = CW'(1);
      end else begin
        acc_nxt = '0;
        cnt_nxt = '0;
      end
    end else if (accept) begin
      if (at_last) begin
        dout_nxt       = acc_shift;
        dout_valid_nxt = 1'b1;
        acc_nxt        = '0;
        cnt_nxt        = '0;
      end else begin
        acc_nxt = acc_shift;
        cnt_nxt = cnt + CW'(1);
      end
    end

    if (sync && partial) begin
      frame_err_nxt = 1'b1;
    end else if (err_clr) begin
      frame_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: an MSB-first and an LSB-first instance share one
// input stream and are checked against a bit-queue reference model.
module tb_bit_deserializer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         sync = 1'b0;
  logic         dout_ready = 1'b0;
  logic         err_clr = 1'b0;
  logic         din_ready_m, din_ready_l;
  logic [W-1:0] dout_m, dout_l;
  logic         dout_valid_m, dout_valid_l;
  logic         frame_err_m, frame_err_l;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic         q[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_dout_m = '0;
  logic [W-1:0] m_dout_l = '0;
  logic         m_err = 1'b0;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
    .sync(sync), .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .frame_err(frame_err_m), .err_clr(err_clr)
  );

  bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
    .sync(sync), .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .frame_err(frame_err_l), .err_clr(err_clr)
  );

  function automatic logic model_ready(input logic r);
    return !(q.size() == W - 1 && m_valid && !r);
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid  = 1'b0;
    m_dout_m = '0;
    m_dout_l = '0;
    m_err    = 1'b0;
  endtask

  // Drive one cycle of inputs at negedge, advance the model, return at posedge+1.
  task automatic step(input logic b, input logic v, input logic s, input logic r, input logic c);
    logic acc;
    @(negedge clk);
    din = b; din_valid = v; sync = s; dout_ready = r; err_clr = c;
    acc = v && model_ready(r);
    if (m_valid && r) m_valid = 1'b0;
    if (s && q.size() != 0) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    if (s) q.delete();
    if (acc) begin
      q.push_back(b);
      if (q.size() == W) begin
        m_dout_m = '0;
        m_dout_l = '0;
        for (int i = 0; i < W; i++) begin
          m_dout_m[W-1-i] = q[i];
          m_dout_l[i]     = q[i];
        end
        m_valid = 1'b1;
        q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic lsb, input logic r);
    for (int i = 0; i < W; i++) step(lsb ? w[i] : w[W-1-i], 1'b1, 1'b0, r, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++; if (dout_valid_m !== 1'b0) begin miscompares++; $display("FAIL reset dout_valid: got %b want 0", dout_valid_m); end
    vectors++; if (dout_m !== 12'h000) begin miscompares++; $display("FAIL reset dout: got %h want 000", dout_m); end
    vectors++; if (frame_err_m !== 1'b0) begin miscompares++; $display("FAIL reset frame_err: got %b want 0", frame_err_m); end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (din_ready_m !== 1'b1) begin miscompares++; $display("FAIL reset din_ready: got %b want 1", din_ready_m); end
    vectors++; if (dout_valid_l !== 1'b0) begin miscompares++; $display("FAIL reset dout_valid_l: got %b want 0", dout_valid_l); end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w;
    w = 12'hA5C;
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], 1'b1, 1'b0, 1'b1, 1'b0);
      if (i < W - 1) begin
        vectors++; if (dout_valid_m !== 1'b0) begin miscompares++; $display("FAIL msb early valid bit %0d: got %b want 0", i, dout_valid_m); end
      end
    end
    vectors++; if (dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL msb valid: got %b want 1", dout_valid_m); end
    vectors++; if (dout_m !== 12'hA5C) begin miscompares++; $display("FAIL msb dout: got %h want a5c", dout_m); end
    vectors++; if (dout_l !== m_dout_l) begin miscompares++; $display("FAIL msb stream on lsb dut: got %h want %h", dout_l, m_dout_l); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (dout_valid_m !== 1'b0) begin miscompares++; $display("FAIL msb valid one cycle: got %b want 0", dout_valid_m); end
    vectors++; if (dout_m !== 12'hA5C) begin miscompares++; $display("FAIL msb dout hold: got %h want a5c", dout_m); end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] words [3];
    words[0] = 12'hA5C; words[1] = 12'h001; words[2] = 12'hFFF;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) begin
        step(words[k][i], 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++; if (din_ready_l !== 1'b1) begin miscompares++; $display("FAIL lsb din_ready w%0d b%0d: got %b want 1", k, i, din_ready_l); end
      end
      vectors++; if (dout_valid_l !== 1'b1) begin miscompares++; $display("FAIL lsb valid w%0d: got %b want 1", k, dout_valid_l); end
      vectors++; if (dout_l !== words[k]) begin miscompares++; $display("FAIL lsb dout w%0d: got %h want %h", k, dout_l, words[k]); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    send_word(12'h123, 1'b0, 1'b0);
    vectors++; if (dout_m !== 12'h123 || dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL bp first word: got %h/%b want 123/1", dout_m, dout_valid_m); end
    w = 12'h456;
    for (int i = 0; i < W - 1; i++) begin
      vectors++; if (din_ready_m !== 1'b1) begin miscompares++; $display("FAIL bp ready bit %0d: got %b want 1", i, din_ready_m); end
      step(w[W-1-i], 1'b1, 1'b0, 1'b0, 1'b0);
    end
    vectors++; if (din_ready_m !== 1'b0) begin miscompares++; $display("FAIL bp stall: got %b want 0", din_ready_m); end
    step(w[0], 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (din_ready_m !== 1'b0) begin miscompares++; $display("FAIL bp still stalled: got %b want 0", din_ready_m); end
    vectors++; if (dout_m !== 12'h123 || dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL bp held: got %h/%b want 123/1", dout_m, dout_valid_m); end
    step(w[0], 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++; if (dout_m !== 12'h456 || dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL bp swap: got %h/%b want 456/1", dout_m, dout_valid_m); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (dout_valid_m !== 1'b0 || dout_m !== 12'h456) begin miscompares++; $display("FAIL bp drain: got %h/%b want 456/0", dout_m, dout_valid_m); end
  endtask

  task automatic test_sync();
    logic [W-1:0] w;
    w = 12'h7E1;
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
      vectors++; if (dout_valid_m !== 1'b0) begin miscompares++; $display("FAIL sync junk output bit %0d: got %b want 0", i, dout_valid_m); end
    end
    step(w[W-1], 1'b1, 1'b1, 1'b1, 1'b0);
    vectors++; if (frame_err_m !== 1'b1) begin miscompares++; $display("FAIL sync frame_err set: got %b want 1", frame_err_m); end
    for (int i = 1; i < W; i++) step(w[W-1-i], 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++; if (dout_m !== 12'h7E1 || dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL sync realigned: got %h/%b want 7e1/1", dout_m, dout_valid_m); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++; if (frame_err_m !== 1'b0) begin miscompares++; $display("FAIL sync err_clr: got %b want 0", frame_err_m); end
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    vectors++; if (frame_err_m !== 1'b1) begin miscompares++; $display("FAIL sync set beats clr: got %b want 1", frame_err_m); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vectors++; if (frame_err_m !== 1'b1) begin miscompares++; $display("FAIL sync idle partial: got %b want 1", frame_err_m); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vectors++; if (frame_err_m !== 1'b0) begin miscompares++; $display("FAIL sync benign: got %b want 0", frame_err_m); end
    send_word(12'h5A5, 1'b0, 1'b1);
    vectors++; if (dout_m !== 12'h5A5) begin miscompares++; $display("FAIL sync after discard: got %h want 5a5", dout_m); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_gapped();
    logic [W-1:0] w;
    w = 12'h3C3;
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], 1'b1, 1'b0, 1'b1, 1'b0);
      if (i < W - 1) begin
        step(1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++; if (dout_valid_m !== 1'b0) begin miscompares++; $display("FAIL gapped early valid bit %0d: got %b want 0", i, dout_valid_m); end
      end
    end
    vectors++; if (dout_m !== 12'h3C3 || dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL gapped word: got %h/%b want 3c3/1", dout_m, dout_valid_m); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom), ($urandom_range(99) < 75), ($urandom_range(99) < 3),
           ($urandom_range(99) < 70), ($urandom_range(99) < 5));
      vectors++; if (din_ready_m !== model_ready(dout_ready) || din_ready_l !== model_ready(dout_ready)) begin miscompares++; $display("FAIL rand din_ready cyc %0d: got %b/%b want %b", n, din_ready_m, din_ready_l, model_ready(dout_ready)); end
      vectors++; if (dout_valid_m !== m_valid || dout_valid_l !== m_valid) begin miscompares++; $display("FAIL rand dout_valid cyc %0d: got %b/%b want %b", n, dout_valid_m, dout_valid_l, m_valid); end
      vectors++; if (dout_m !== m_dout_m) begin miscompares++; $display("FAIL rand dout_m cyc %0d: got %h want %h", n, dout_m, m_dout_m); end
      vectors++; if (dout_l !== m_dout_l) begin miscompares++; $display("FAIL rand dout_l cyc %0d: got %h want %h", n, dout_l, m_dout_l); end
      vectors++; if (frame_err_m !== m_err || frame_err_l !== m_err) begin miscompares++; $display("FAIL rand frame_err cyc %0d: got %b/%b want %b", n, frame_err_m, frame_err_l, m_err); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midword();
    send_word(12'h2B4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++; if (dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL rstmid pre valid: got %b want 1", dout_valid_m); end
    #2;
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++; if (dout_valid_m !== 1'b0 || dout_valid_l !== 1'b0) begin miscompares++; $display("FAIL rstmid valid: got %b/%b want 0", dout_valid_m, dout_valid_l); end
    vectors++; if (dout_m !== 12'h000 || dout_l !== 12'h000) begin miscompares++; $display("FAIL rstmid dout: got %h/%h want 000", dout_m, dout_l); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (dout_valid_m !== 1'b0) begin miscompares++; $display("FAIL rstmid spurious valid: got %b want 0", dout_valid_m); end
    send_word(12'h800, 1'b0, 1'b1);
    vectors++; if (dout_m !== 12'h800 || dout_valid_m !== 1'b1) begin miscompares++; $display("FAIL rstmid new word: got %h/%b want 800/1", dout_m, dout_valid_m); end
    vectors++; if (dout_l !== 12'h001) begin miscompares++; $display("FAIL rstmid new word lsb dut: got %h want 001", dout_l); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_sync();
    test_gapped();
    test_random();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
